// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / parity frame receiver pair.
// Both ends of the link use calc_parity so the parity rule lives in one place.
package parity_pkg;

   // Receiver frame state: start bit seen in IDLE, then data, parity, stop.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_e;

   localparam logic PARITY_EVEN     = 1'b0;
   localparam logic PARITY_ODD_MODE = 1'b1;

   // Widest data word either end supports; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int MAX_DATA_W = 16;

   // Parity bit a transmitter appends so that XOR(data, parity) == odd.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/parity_err_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module parity_err_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise count up until all-ones and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, parity bit,
// stop bit. Bits are taken only on sin_valid strobes from the link front-end.
// Each completed frame is presented for one cycle with parity/framing flags,
// and parity failures are tallied in a saturating counter.
module parity_frame_rx
   import parity_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter bit PARITY_ODD = 1'b0,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              sin_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy,
   output logic [CNT_W-1:0]  err_cnt,
   input  logic              err_cnt_clr
);

   // Bit counter only needs to reach DATA_W-1; the last data bit moves on.
   localparam int                BCNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

   rx_state_e state_q, state_d;

   logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
   logic [DATA_W-1:0]     shreg_q, shreg_d;
   logic                  par_q, par_d;
   logic [DATA_W-1:0]     dout_q, dout_d;
   logic                  dvld_q, dvld_d;
   logic                  perr_q, perr_d;
   logic                  ferr_q, ferr_d;

   logic [DATA_W-1:0]     shifted;
   logic [MAX_DATA_W-1:0] data_ext;
   logic                  stop_accept;
   logic                  frame_perr;

   // New bits enter at the MSB end so the first data bit lands in bit 0.
   generate
      if (DATA_W == 1) begin : g_shift_1
         assign shifted = sin;
      end else begin : g_shift_n
         assign shifted = {sin, shreg_q[DATA_W-1:1]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: advance only on strobes; a low bit on an idle line is a start bit.
   always_comb begin
      state_d = state_q;
      if (sin_valid) begin
         case (state_q)
            IDLE:    if (!sin) state_d = DATA;
            DATA:    if (bcnt_q == LAST_BIT) state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: busy whenever a frame is in progress.
   always_comb begin
      busy = (state_q != IDLE);
   end

   // Frame assembly: bit counter, data shift register and captured parity bit.
   always_comb begin
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      if (sin_valid) begin
         case (state_q)
            IDLE: begin
               if (!sin) bcnt_d = '0;
            end
            DATA: begin
               shreg_d = shifted;
               bcnt_d  = bcnt_q + BCNT_W'(1);
            end
            PARITY: begin
               par_d = sin;
            end
            default: begin
            end
         endcase
      end
   end

   // Parity check over the assembled data word and the captured parity bit.
   always_comb begin
      data_ext               = '0;
      data_ext[DATA_W-1:0]   = shreg_q;
      stop_accept            = sin_valid && (state_q == STOP);
      frame_perr             = (par_q != calc_parity(data_ext, PARITY_ODD));
   end

   // Result update: outputs change only on the edge that takes the stop bit.
   always_comb begin
      dout_d = dout_q;
      perr_d = perr_q;
      ferr_d = ferr_q;
      dvld_d = 1'b0;
      if (stop_accept) begin
         dout_d = shreg_q;
         perr_d = frame_perr;
         ferr_d = ~sin;
         dvld_d = 1'b1;
      end
   end

   // Datapath and result registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q  <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         dout_q  <= '0;
         dvld_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         dvld_q  <= dvld_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   parity_err_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (err_cnt_clr),
      .inc_i (stop_accept && frame_perr),
      .cnt_o (err_cnt)
   );

   assign data_out   = dout_q;
   assign data_valid = dvld_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Receive-side counterpart of the team's parity generator.
- Deserialises a framed serial stream (start bit, DATA_W data bits LSB-first, parity bit, stop bit) and checks the parity bit against the data.
- Presents each received word with a one-cycle valid pulse, parity and framing error flags, and a saturating parity-error counter.
- Sits between the serial link front-end (which supplies bit-enable strobes) and the word-level consumer.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- PARITY_ODD, 0, 0 = even parity expected (XOR of data and parity bit is 0); 1 = odd parity expected (XOR is 1).
- CNT_W, 8, width of the parity-error counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  strobe: sin is a valid bit this cycle; sin is ignored when low.
- data_out  output  DATA_W  last received data word, held until the next frame completes.
- data_valid  output  1  one-cycle pulse: data_out, parity_err and frame_err are updated.
- parity_err  output  1  parity mismatch on the last frame; valid with data_valid, held after.
- frame_err  output  1  stop bit sampled as 0 on the last frame; held after.
- busy  output  1  high in any state other than IDLE.
- err_cnt  output  CNT_W  count of frames with parity_err, saturating at all-ones.
- err_cnt_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - When rst is asserted: state = IDLE, bit counter = 0, shift register = 0, data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, err_cnt = 0, busy = 0.
  - rst mid-frame discards the partial frame and produces no data_valid.
- Bit acceptance: the FSM advances only on cycles where sin_valid = 1. Gaps of any length between strobes are legal and leave all state unchanged.
- FSM states:
  - IDLE:
    - sin_valid & sin = 0 → DATA, clear the bit counter (this is the start bit).
    - sin_valid & sin = 1 → stay in IDLE (idle line).
  - DATA:
    - Each strobe shifts sin in at the MSB end of the shift register, so the first data bit ends up at bit 0.
    - The bit counter increments on each strobe.
    - After the DATA_W-th data bit → PARITY.
  - PARITY: on the strobe, latch sin as the parity bit, then → STOP.
  - STOP: on the strobe, → IDLE, and on the next rising edge:
    - data_out ← shift register.
    - parity_err ← (XOR of data and parity bit) != PARITY_ODD.
    - frame_err ← ~sin.
    - data_valid = 1 for exactly one cycle.
- Latency: data_valid asserts on the first cycle after the clock edge that accepts the stop bit.
- Back-to-back frames:
  - A start bit may be accepted on the cycle immediately after the stop bit, including the data_valid cycle.
  - The output registers are not disturbed until that next frame completes.
- Framing errors: frame_err does not suppress data_valid; the word is still presented with the flag set.
- err_cnt:
  - Increments on the same edge that sets parity_err = 1.
  - Holds at 2^CNT_W − 1 once saturated.
  - err_cnt_clr has priority over an increment in the same cycle, so the result is 0.
- Parity is evaluated over exactly DATA_W data bits plus the parity bit. The start and stop bits are excluded.
- busy is combinational from the state: busy = (state != IDLE).

Decomposition:
- Shared package parity_pkg:
  - State enum: IDLE, DATA, PARITY, STOP (2-bit encoding).
  - Constant PARITY_EVEN = 0, PARITY_ODD_MODE = 1.
  - Function calc_parity(data, odd), which the transmitter-side generator also uses, so both ends share one definition.
- One natural sub-module: parity_err_counter, the saturating counter with clear and increment, parameterised by CNT_W.
- Shift register and FSM stay in the top module.

Test Plan:
- Even mode (PARITY_ODD = 0): send frame 0, data 0xA5 LSB-first, parity 0, stop 1 with sin_valid every cycle → data_valid pulse one cycle after the stop strobe; data_out = 0xA5, parity_err = 0, frame_err = 0, err_cnt = 0.
- Even mode: send data 0x07 with parity 0 (wrong; correct parity is 1) → data_out = 0x07, parity_err = 1, err_cnt = 1. Then send data 0x07 with parity 1 → parity_err = 0, err_cnt stays 1.
- Odd mode (PARITY_ODD = 1): send data 0x00 with parity 1 and stop 0 → parity_err = 0, frame_err = 1, data_valid still pulses, data_out = 0x00.
- Send data 0x3C with parity 0, inserting 0–5 idle cycles (sin_valid = 0, sin randomised) between strobes → same result as the gap-free case: data_out = 0x3C, no errors. Then start a second frame (0xC3) on the cycle after the stop bit → two data_valid pulses, outputs 0x3C then 0xC3.
- Assert rst after 4 data bits of a frame → no data_valid, busy = 0 on the next cycle. A following clean frame 0x5A is received correctly.
- CNT_W = 2: send 4 bad-parity frames → err_cnt = 1, 2, 3, 3. Assert err_cnt_clr in the same cycle as a 5th error → err_cnt = 0.
